// File: rtl/tetris_input_pkg.sv
// Shared constants for the joystick/button input conditioner: button bit
// positions, CPU command codes, the auto-repeat mask and repeat FSM states.
package tetris_input_pkg;

  localparam int NUM_BTN = 7;

  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_SL    = 4;
  localparam int BTN_SR    = 5;
  localparam int BTN_HOLD  = 6;

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_RIGHT = 4'd2;
  localparam logic [3:0] CMD_DOWN  = 4'd3;
  localparam logic [3:0] CMD_LEFT  = 4'd4;
  localparam logic [3:0] CMD_SL    = 4'd7;
  localparam logic [3:0] CMD_SR    = 4'd8;
  localparam logic [3:0] CMD_HOLD  = 4'd9;

  // Only Right, Down and Left auto-repeat while held.
  localparam logic [6:0] REPEAT_MASK = 7'b0001110;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DAS,
    RPT_ARR
  } rpt_state_e;

  // Maps a button bit position to the command code the CPU sees.
  function automatic logic [3:0] btn_to_cmd(input int idx);
    case (idx)
      BTN_UP:    return CMD_UP;
      BTN_RIGHT: return CMD_RIGHT;
      BTN_DOWN:  return CMD_DOWN;
      BTN_LEFT:  return CMD_LEFT;
      BTN_SL:    return CMD_SL;
      BTN_SR:    return CMD_SR;
      BTN_HOLD:  return CMD_HOLD;
      default:   return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button line: two-flop synchroniser, stability counter that flips the
// debounced level only after a long enough steady mismatch, and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             levelDly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous pin into the clock domain before anything looks at it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the input disagrees with the level; flip once the run is long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state plus a delayed copy of the level for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      level_q    <= 1'b0;
      levelDly_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      levelDly_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~levelDly_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Joystick/button front end for the CPU: seven debounced lines, delayed
// auto-repeat on Right/Down/Left, a fixed-priority pick of same-cycle events
// and a single-entry command latch read and acknowledged by the processor.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DAS_CYCLES      = 8333333,
  parameter int ARR_CYCLES      = 1666666,
  parameter int CNT_W           = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  btn_raw,
  input  logic        rd_ack,
  output logic        cmd_valid,
  output logic [31:0] cmd_code,
  output logic [6:0]  btn_level,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rptEvent;
  logic [NUM_BTN-1:0] events;

  rpt_state_e       rptState_q [NUM_BTN];
  rpt_state_e       rptState_d [NUM_BTN];
  logic [CNT_W-1:0] rptCnt_q   [NUM_BTN];
  logic [CNT_W-1:0] rptCnt_d   [NUM_BTN];

  logic       evValid;
  logic [3:0] evCode;

  logic       valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic       overrun_q, overrun_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (btn_raw[g]),
      .level_o(level[g]),
      .rise_o (press[g])
    );
  end

  // Repeat FSMs: wait the DAS delay after a press, then fire every ARR period until release.
  always_comb begin
    rptEvent = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rptState_d[i] = rptState_q[i];
      rptCnt_d[i]   = rptCnt_q[i];
      if (REPEAT_MASK[i]) begin
        case (rptState_q[i])
          RPT_IDLE: begin
            if (press[i]) begin
              rptState_d[i] = RPT_DAS;
              rptCnt_d[i]   = '0;
            end
          end
          RPT_DAS: begin
            if (!level[i]) begin
              rptState_d[i] = RPT_IDLE;
              rptCnt_d[i]   = '0;
            end else if (rptCnt_q[i] == DAS_LAST) begin
              rptState_d[i] = RPT_ARR;
              rptCnt_d[i]   = '0;
              rptEvent[i]   = 1'b1;
            end else begin
              rptCnt_d[i] = rptCnt_q[i] + CNT_W'(1);
            end
          end
          RPT_ARR: begin
            if (!level[i]) begin
              rptState_d[i] = RPT_IDLE;
              rptCnt_d[i]   = '0;
            end else if (rptCnt_q[i] == ARR_LAST) begin
              rptCnt_d[i] = '0;
              rptEvent[i] = 1'b1;
            end else begin
              rptCnt_d[i] = rptCnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            rptState_d[i] = RPT_IDLE;
            rptCnt_d[i]   = '0;
          end
        endcase
      end else begin
        rptState_d[i] = RPT_IDLE;
        rptCnt_d[i]   = '0;
      end
    end
  end

  // Repeat FSM state and counters.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (reset) begin
        rptState_q[i] <= RPT_IDLE;
        rptCnt_q[i]   <= '0;
      end else begin
        rptState_q[i] <= rptState_d[i];
        rptCnt_q[i]   <= rptCnt_d[i];
      end
    end
  end

  assign events = press | rptEvent;

  // Keep only the highest-index event; scanning upward lets later bits override earlier ones.
  always_comb begin
    evValid = 1'b0;
    evCode  = CMD_NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (events[i]) begin
        evValid = 1'b1;
        evCode  = btn_to_cmd(i);
      end
    end
  end

  // Single-entry latch: an ack in the same cycle frees the slot for a new event.
  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = 1'b0;
    if (evValid) begin
      if (!valid_q || rd_ack) begin
        valid_d = 1'b1;
        code_d  = evCode;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_ack) begin
      valid_d = 1'b0;
      code_d  = CMD_NONE;
    end
  end

  // Latch and overrun pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      code_q    <= CMD_NONE;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = {28'd0, code_q};
  assign btn_level = level;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: a timestamp-based reference model predicts the
// outputs after every clock edge into a queue, and a monitor compares the DUT
// against it on the falling edge. Directed scenarios are followed by random
// button/ack activity.
module tb_tetris_input_ctrl;
  import tetris_input_pkg::*;

  localparam int DEB = 4;
  localparam int DAS = 20;
  localparam int ARR = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  btn_raw;
  logic        rd_ack;
  logic        cmd_valid;
  logic [31:0] cmd_code;
  logic [6:0]  btn_level;
  logic        overrun;

  int nChecks = 0;
  int nFails  = 0;
  int ovCount = 0;
  int loadCount = 0;
  bit autoAck = 1'b0;

  typedef struct packed {
    logic        valid;
    logic [31:0] code;
    logic [6:0]  level;
    logic        ov;
  } exp_t;

  exp_t expQ[$];

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR),
    .CNT_W          (24)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .rd_ack   (rd_ack),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .btn_level(btn_level),
    .overrun  (overrun)
  );

  initial forever #5 clock = ~clock;

  // Reference model state: debounced levels, mismatch run lengths, press timestamps, latch.
  int       cmdOf[7] = '{1, 2, 3, 4, 7, 8, 9};
  bit [6:0] mLevel, mPrev, held;
  int       mRun[7];
  int       pressAt[7];
  bit [6:0] rawHist[$];
  bit       mValid, mOv;
  int       mCode;
  int       cyc = 0;

  task automatic modelReset();
    mLevel = '0;
    mPrev  = '0;
    held   = '0;
    mValid = 1'b0;
    mOv    = 1'b0;
    mCode  = 0;
    for (int i = 0; i < 7; i++) begin
      mRun[i]    = 0;
      pressAt[i] = 0;
    end
    rawHist.delete();
    rawHist.push_back(7'd0);
    rawHist.push_back(7'd0);
  endtask

  task automatic modelStep();
    int       best;
    bit       ev;
    bit [6:0] syncIn;
    cyc++;
    if (reset) begin
      modelReset();
    end else begin
      best = -1;
      for (int i = 0; i < 7; i++) begin
        ev = mLevel[i] && !mPrev[i];
        if (REPEAT_MASK[i]) begin
          if (ev) begin
            held[i]    = 1'b1;
            pressAt[i] = cyc;
          end
          if (!mLevel[i]) held[i] = 1'b0;
          if (held[i] && (cyc - pressAt[i]) >= DAS && ((cyc - pressAt[i] - DAS) % ARR) == 0)
            ev = 1'b1;
        end
        if (ev) best = i;
      end
      mOv = 1'b0;
      if (best >= 0) begin
        if (!mValid || rd_ack) begin
          mValid = 1'b1;
          mCode  = cmdOf[best];
        end else begin
          mOv = 1'b1;
        end
      end else if (rd_ack) begin
        mValid = 1'b0;
        mCode  = 0;
      end
      syncIn = rawHist[rawHist.size() - 2];
      mPrev  = mLevel;
      for (int i = 0; i < 7; i++) begin
        if (syncIn[i] != mLevel[i]) begin
          mRun[i]++;
          if (mRun[i] == DEB) begin
            mLevel[i] = ~mLevel[i];
            mRun[i]   = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      rawHist.push_back(btn_raw);
      if (rawHist.size() > 4) void'(rawHist.pop_front());
    end
    expQ.push_back({mValid, 32'(mCode), mLevel, mOv});
  endtask

  // Predict the post-edge outputs on every rising edge.
  initial begin
    modelReset();
    forever begin
      @(posedge clock);
      modelStep();
    end
  end

  // Monitor: compare each presented output against the oldest prediction.
  initial begin
    exp_t e;
    bit   prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nChecks++;
        if ({cmd_valid, cmd_code, btn_level, overrun} !== e) begin
          nFails++;
          $display("[TB] FAIL sb t=%0t actual valid=%0b code=%0d level=%b ov=%0b required valid=%0b code=%0d level=%b ov=%0b",
                   $time, cmd_valid, cmd_code, btn_level, overrun, e.valid, e.code, e.level, e.ov);
        end
      end
      if (overrun === 1'b1) ovCount++;
      if (cmd_valid === 1'b1 && !prevValid) loadCount++;
      prevValid = (cmd_valid === 1'b1);
    end
  end

  task automatic stepCycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (autoAck) rd_ack = cmd_valid;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] raw, input int n);
    btn_raw = raw;
    stepCycles(n);
  endtask

  task automatic ackOnce();
    rd_ack = 1'b1;
    stepCycles(1);
    rd_ack = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin
    int ovBefore;
    int loadBefore;
    int b;
    reset   = 1'b1;
    btn_raw = '0;
    rd_ack  = 1'b0;
    stepCycles(3);
    reset = 1'b0;
    stepCycles(2);
    checkOutput("reset_valid", 32'(cmd_valid), 32'd0);
    checkOutput("reset_level", 32'(btn_level), 32'd0);

    $display("[TB] glitch reject");
    applyStimulus(7'h01, 3);
    applyStimulus(7'h00, 10);
    checkOutput("glitch_level", 32'(btn_level), 32'd0);
    checkOutput("glitch_valid", 32'(cmd_valid), 32'd0);

    $display("[TB] clean press");
    applyStimulus(7'h40, 10);
    checkOutput("press_valid", 32'(cmd_valid), 32'd1);
    checkOutput("press_code", cmd_code, 32'd9);
    ackOnce();
    checkOutput("ack_valid", 32'(cmd_valid), 32'd0);
    checkOutput("ack_code", cmd_code, 32'd0);
    stepCycles(30);
    checkOutput("held_no_repeat", 32'(cmd_valid), 32'd0);
    applyStimulus(7'h00, 10);

    $display("[TB] priority");
    ovBefore = ovCount;
    applyStimulus(7'h41, 10);
    checkOutput("prio_code", cmd_code, 32'd9);
    checkOutput("prio_no_overrun", 32'(ovCount - ovBefore), 32'd0);
    ackOnce();
    applyStimulus(7'h00, 10);
    applyStimulus(7'h01, 10);
    checkOutput("up_code", cmd_code, 32'd1);
    ackOnce();
    applyStimulus(7'h00, 10);

    $display("[TB] auto-repeat");
    autoAck    = 1'b1;
    loadBefore = loadCount;
    applyStimulus(7'h08, 40);
    applyStimulus(7'h00, 30);
    autoAck = 1'b0;
    rd_ack  = 1'b0;
    checkOutput("repeat_events", 32'(loadCount - loadBefore), 32'd5);

    $display("[TB] overrun and same-cycle ack");
    ovBefore = ovCount;
    applyStimulus(7'h20, 10);
    checkOutput("sr_code", cmd_code, 32'd8);
    applyStimulus(7'h30, 10);
    checkOutput("sl_dropped_code", cmd_code, 32'd8);
    checkOutput("sl_overrun", 32'(ovCount - ovBefore), 32'd1);
    btn_raw = 7'h34;
    stepCycles(6);
    rd_ack = 1'b1;
    stepCycles(1);
    rd_ack = 1'b0;
    checkOutput("down_valid", 32'(cmd_valid), 32'd1);
    checkOutput("down_code", cmd_code, 32'd3);
    stepCycles(1);
    checkOutput("down_no_overrun", 32'(ovCount - ovBefore), 32'd1);
    applyStimulus(7'h00, 10);
    ackOnce();
    stepCycles(2);

    $display("[TB] reset mid-repeat");
    applyStimulus(7'h02, 35);
    checkOutput("arr_valid", 32'(cmd_valid), 32'd1);
    checkOutput("arr_code", cmd_code, 32'd2);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_code", cmd_code, 32'd0);
    checkOutput("rst_level", 32'(btn_level), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    stepCycles(5);
    checkOutput("rst_redebounce", 32'(cmd_valid), 32'd0);
    stepCycles(3);
    checkOutput("rst_repress_valid", 32'(cmd_valid), 32'd1);
    checkOutput("rst_repress_code", cmd_code, 32'd2);
    applyStimulus(7'h00, 10);
    ackOnce();

    $display("[TB] random activity");
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(0, 6));
        btn_raw[b] = ~btn_raw[b];
      end
      rd_ack = ($urandom_range(0, 3) == 0);
      stepCycles(1);
    end
    rd_ack = 1'b0;
    applyStimulus(7'h00, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
